// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO special-register pair with an iterative
// signed/unsigned multiply/divide engine, direct HI/LO writes and a
// combinational HI/LO read port onto the datapath bus.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             HIout,
  input  logic             LOout,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;

  // Engine working registers: acc holds the product accumulator for
  // multiply, or {remainder, quotient/dividend} for divide.
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 op_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 dz_op;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 accept;
  logic                 is_arith;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;

  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  // Two's-complement negate when n is set; MIN maps onto itself, which
  // is exactly the unsigned magnitude 2^(WIDTH-1) we want to hold.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign a_s      = a;
  assign b_s      = b;
  assign a_neg    = !op[0] && (a_s < 0);
  assign b_neg    = !op[0] && (b_s < 0);
  assign mag_a    = cond_neg(a, a_neg);
  assign mag_b    = cond_neg(b, b_neg);
  assign is_arith = !op[2];
  assign accept   = (state == IDLE) && start && !abort;

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (div_diff[WIDTH])
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction of the finished magnitudes; divide-by-zero forces an
  // all-ones quotient while the remainder path already reproduces a.
  always_comb begin
    prod   = cond_neg2(acc, neg_q);
    quo    = dz_op ? '1 : cond_neg(acc[WIDTH-1:0], neg_q);
    rem    = cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
    res_hi = op_div ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo = op_div ? quo : prod[WIDTH-1:0];
  end

  // Datapath registers: operand capture on launch, one step per RUN cycle.
  always_ff @(posedge Clock) begin
    if (accept && is_arith) begin
      op_div <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dz_op  <= op[1] && (b == '0);
      if (op[1]) begin
        opnd <= mag_b;
        acc  <= {{WIDTH{1'b0}}, mag_a};
      end else begin
        opnd <= mag_a;
        acc  <= {{WIDTH{1'b0}}, mag_b};
      end
    end else if (state == RUN) begin
      acc <= op_div ? div_next : mul_next;
    end
  end

  // Control FSM with registered HI/LO, busy, done and div_by_zero.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_arith) begin
              state       <= RUN;
              busy        <= 1'b1;
              count       <= '0;
              div_by_zero <= 1'b0;
            end else if (op == 3'b100) begin
              hi          <= a;
              div_by_zero <= 1'b0;
            end else if (op == 3'b101) begin
              lo          <= a;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1))
              state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!abort) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
            if (op_div)
              div_by_zero <= dz_op;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Bus read port: HI has priority over LO.
  always_comb begin
    bus_out = '0;
    if (HIout)
      bus_out = hi;
    else if (LOout)
      bus_out = lo;
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_hilo_muldiv_unit;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          Clear;
  logic          start32, abort32, HIout32, LOout32;
  logic [2:0]    op32;
  logic [W-1:0]  a32, b32, bus32, hi32, lo32;
  logic          busy32, done32, dz32;

  logic          start8, abort8, HIout8, LOout8;
  logic [2:0]    op8;
  logic [W8-1:0] a8, b8, bus8, hi8, lo8;
  logic          busy8, done8, dz8;

  hilo_muldiv_unit #(.WIDTH(W)) dut32 (
    .Clock(Clock), .Clear(Clear), .start(start32), .op(op32), .abort(abort32),
    .a(a32), .b(b32), .HIout(HIout32), .LOout(LOout32), .bus_out(bus32),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_by_zero(dz32));

  hilo_muldiv_unit #(.WIDTH(W8)) dut8 (
    .Clock(Clock), .Clear(Clear), .start(start8), .op(op8), .abort(abort8),
    .a(a8), .b(b8), .HIout(HIout8), .LOout(LOout8), .bus_out(bus8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_by_zero(dz8));

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse pops one expected result.
  always @(negedge Clock) begin
    if (Clear === 1'b1 && done32 === 1'b1) begin
      exp_t e;
      if (q32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done32_unexpected: got done at cycle %0d want none", cyc);
      end else begin
        e = q32.pop_front();
        check("hi32", hi32, e.hi);
        check("lo32", lo32, e.lo);
        check("dz32", 32'(dz32), 32'(e.dz));
        check("done32_cycle", cyc, e.cyc);
        check("busy32_at_done", 32'(busy32), 32'd0);
      end
    end
  end

  always @(negedge Clock) begin
    if (Clear === 1'b1 && done8 === 1'b1) begin
      exp_t e;
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done8_unexpected: got done at cycle %0d want none", cyc);
      end else begin
        e = q8.pop_front();
        check("hi8", 32'(hi8), e.hi);
        check("lo8", 32'(lo8), e.lo);
        check("dz8", 32'(dz8), 32'(e.dz));
        check("done8_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue32(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic push, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, output int k);
    exp_t e;
    @(posedge Clock); #1;
    start32 = 1'b1; op32 = o; a32 = av; b32 = bv;
    k = cyc + 1;
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = ed; e.cyc = k + W + 1;
      q32.push_back(e);
    end
    @(posedge Clock); #1;
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eh, input logic [7:0] el, input logic ed);
    exp_t e;
    @(posedge Clock); #1;
    start8 = 1'b1; op8 = o; a8 = av; b8 = bv;
    e.hi = 32'(eh); e.lo = 32'(el); e.dz = ed; e.cyc = cyc + 1 + W8 + 1;
    q8.push_back(e);
    @(posedge Clock); #1;
    start8 = 1'b0;
  endtask

  task automatic drain32(input string name);
    for (int i = 0; i < 200; i++) begin
      if (q32.size() == 0) break;
      @(posedge Clock);
    end
    #1;
    total++;
    if (q32.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d want 0", name, q32.size());
      q32.delete();
    end
  endtask

  task automatic drain8(input string name);
    for (int i = 0; i < 100; i++) begin
      if (q8.size() == 0) break;
      @(posedge Clock);
    end
    #1;
    total++;
    if (q8.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d want 0", name, q8.size());
      q8.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    Clear = 1'b0;
    start32 = 0; abort32 = 0; HIout32 = 0; LOout32 = 0; op32 = 0; a32 = 0; b32 = 0;
    start8 = 0; abort8 = 0; HIout8 = 0; LOout8 = 0; op8 = 0; a8 = 0; b8 = 0;

    // Reset
    repeat (2) @(posedge Clock);
    #1 Clear = 1'b1;
    @(negedge Clock);
    check("rst_hi", hi32, 32'h0);
    check("rst_lo", lo32, 32'h0);
    check("rst_busy", 32'(busy32), 32'd0);
    check("rst_done", 32'(done32), 32'd0);
    check("rst_dz", 32'(dz32), 32'd0);
    check("rst_hi8", 32'(hi8), 32'h0);

    // Multiply / divide with expected latency
    issue32(3'b000, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, k);
    check("busy_mul", 32'(busy32), 32'd1);
    drain32("mul");
    issue32(3'b001, 32'hFFFFFFFF, 32'd2, 1, 32'h00000001, 32'hFFFFFFFE, 0, k);
    drain32("mulu");
    issue32(3'b010, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, k);
    drain32("div");
    issue32(3'b010, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0, k);
    drain32("div_min");

    // Divide by zero, sticky flag, cleared by next start
    issue32(3'b011, 32'h1234, 32'h0, 1, 32'h1234, 32'hFFFFFFFF, 1, k);
    drain32("divu0");
    repeat (3) @(posedge Clock);
    #1 check("dz_sticky", 32'(dz32), 32'd1);
    issue32(3'b000, 32'd5, 32'd6, 1, 32'h0, 32'd30, 0, k);
    check("dz_cleared", 32'(dz32), 32'd0);
    // Back-to-back: next start lands in the done cycle
    while (cyc < k + W) begin @(posedge Clock); #1; end
    issue32(3'b011, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, k);
    drain32("b2b");

    // MTHI/MTLO and bus read port
    issue32(3'b100, 32'hCAFEF00D, 32'h0, 0, 0, 0, 0, k);
    check("mthi_hi", hi32, 32'hCAFEF00D);
    HIout32 = 1'b1;
    #1 check("bus_hi", bus32, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("mthi_busy", 32'(busy32), 32'd0);
    end
    issue32(3'b101, 32'h12345678, 32'h0, 0, 0, 0, 0, k);
    HIout32 = 1'b0; LOout32 = 1'b1;
    #1 check("bus_lo", bus32, 32'h12345678);
    HIout32 = 1'b1;
    #1 check("bus_both", bus32, 32'hCAFEF00D);
    HIout32 = 1'b0; LOout32 = 1'b0;
    #1 check("bus_none", bus32, 32'h0);

    // Op 11x has no effect
    issue32(3'b110, 32'hDEAD, 32'h1, 0, 0, 0, 0, k);
    check("op11x_hi", hi32, 32'hCAFEF00D);
    check("op11x_lo", lo32, 32'h12345678);
    check("op11x_busy", 32'(busy32), 32'd0);

    // Abort in IDLE suppresses a start
    @(posedge Clock); #1;
    start32 = 1'b1; op32 = 3'b000; a32 = 3; b32 = 3; abort32 = 1'b1;
    @(posedge Clock); #1;
    start32 = 1'b0; abort32 = 1'b0;
    check("abort_idle_busy", 32'(busy32), 32'd0);

    // Abort at RUN iteration 10 with preloaded HI/LO
    issue32(3'b100, 32'h11111111, 32'h0, 0, 0, 0, 0, k);
    issue32(3'b101, 32'h22222222, 32'h0, 0, 0, 0, 0, k);
    issue32(3'b000, 32'd9, 32'd9, 0, 0, 0, 0, k);
    repeat (9) begin @(posedge Clock); #1; end
    abort32 = 1'b1;
    @(posedge Clock); #1;
    abort32 = 1'b0;
    check("abort_busy", 32'(busy32), 32'd0);
    check("abort_hi", hi32, 32'h11111111);
    check("abort_lo", lo32, 32'h22222222);
    repeat (40) @(posedge Clock);
    #1 check("abort_hi_late", hi32, 32'h11111111);

    // Start while busy is ignored
    issue32(3'b000, 32'd3, 32'd4, 1, 32'h0, 32'd12, 0, k);
    repeat (5) begin @(posedge Clock); #1; end
    issue32(3'b010, 32'd100, 32'd5, 0, 0, 0, 0, k);
    check("busy_ignored_start", 32'(busy32), 32'd1);
    drain32("busy_start");

    // Clear pulse mid-RUN
    issue32(3'b000, 32'd7, 32'd7, 0, 0, 0, 0, k);
    repeat (5) begin @(posedge Clock); #1; end
    Clear = 1'b0;
    #1;
    check("clr_hi", hi32, 32'h0);
    check("clr_lo", lo32, 32'h0);
    check("clr_busy", 32'(busy32), 32'd0);
    check("clr_done", 32'(done32), 32'd0);
    check("clr_dz", 32'(dz32), 32'd0);
    @(posedge Clock); #1;
    Clear = 1'b1;
    repeat (40) @(posedge Clock);
    #1 check("clr_busy_late", 32'(busy32), 32'd0);

    // WIDTH = 8 regression
    issue8(3'b000, 8'h80, 8'h80, 8'h40, 8'h00, 0);
    drain8("mul8");
    HIout8 = 1'b1;
    #1 check("bus8_hi", 32'(bus8), 32'h40);
    HIout8 = 1'b0;
    issue8(3'b010, 8'h80, 8'hFF, 8'h00, 8'h80, 0);
    drain8("div8_min");
    issue8(3'b010, 8'h80, 8'h03, 8'hFE, 8'hD6, 0);
    drain8("div8");
    issue8(3'b010, 8'hFB, 8'h00, 8'hFB, 8'hFF, 1);
    drain8("div8_zero");
    issue8(3'b001, 8'hFF, 8'hFF, 8'hFE, 8'h01, 0);
    drain8("mulu8");

    repeat (2) @(posedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised HI/LO special-register unit with an iterative multiply/divide engine; successor to the fixed 32-bit HI/LO register pair in the datapath. It executes signed/unsigned multiply and divide over WIDTH cycles and supports direct HI/LO writes (mthi/mtlo). It drives HI or LO onto the datapath bus under HIout/LOout control (mfhi/mflo). It sits beside the ALU/Z path and is sequenced by the control unit through a start/busy/done handshake.

## Interface
- WIDTH, 32, operand/register width in bits (≥4, even)
- Clock  in  1  system clock, rising edge
- Clear  in  1  asynchronous, active-low reset
- start  in  1  launch op; sampled on rising edge, accepted only in IDLE
- op  in  3  000 MUL, 001 MULU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored (no effect)
- abort  in  1  synchronous cancel of a running MUL/DIV
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- b  in  WIDTH  multiplier / divisor
- HIout  in  1  drive HI onto bus_out
- LOout  in  1  drive LO onto bus_out
- bus_out  out  WIDTH  HI if HIout, else LO if LOout, else 0 (combinational)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  engine running
- done  out  1  one-cycle pulse: result committed
- div_by_zero  out  1  last DIV/DIVU had b = 0; sticky until next accepted start

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start + MUL/MULU/DIV/DIVU: latch operand magnitudes (signed ops: two's-complement absolute value; |MIN| = 2^(WIDTH-1), held unsigned), result-sign flags, count = 0 → RUN.
- IDLE + start + MTHI/MTLO: write a to HI/LO at that edge; state stays IDLE; no busy, no done.
- IDLE + start + op 11x: no effect.
- RUN: one iteration per edge, count += 1.
  - Multiply: shift-add over 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After the WIDTH-th iteration → FIX.
- FIX → IDLE. Apply sign correction and write HI/LO in the same edge; done = 1 for the following cycle.
- Multiply: {HI, LO} = full 2·WIDTH product; signed product negative iff exactly one operand negative.
- Divide: LO = quotient, HI = remainder.
  - Quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - MIN / −1 signed: LO = MIN, HI = 0 (wrap, no trap).
- Divide by zero: HI = a, LO = all-ones, div_by_zero = 1; takes full latency like a normal divide.
- abort in RUN or FIX: → IDLE at that edge. HI/LO unchanged, no done, div_by_zero unchanged. abort in IDLE: ignored; also suppresses any start at the same edge.
- start while busy: ignored, no queuing.
- HIout and LOout both high: HI wins.

## Timing
- Reset (Clear low, async): hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, state IDLE, count = 0. Outputs hold these values until Clear is released.
- start accepted at edge k:
  - busy = 1 from after k through the cycle before edge k+WIDTH+1.
  - FIX occupies the cycle after edge k+WIDTH.
  - HI/LO update at edge k+WIDTH+1; done = 1 for exactly that following cycle; busy = 0 in the same cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted (state is IDLE).
- MTHI/MTLO: HI/LO visible the cycle after the accepting edge.
- bus_out and hi/lo reads see the register value; a new result appears only after its commit edge.
- Clear asserted mid-operation: immediate return to reset values; partial results discarded.

## Test plan
- Reset: hold Clear low 2 cycles, then release → hi = lo = 0, busy = done = div_by_zero = 0.
- WIDTH = 32, MUL a = 0xFFFFFFFD (−3), b = 7 → done at edge k+33; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULU a = 0xFFFFFFFF, b = 2 → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV a = 0x80000000, b = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU a = 0x1234, b = 0 → HI = 0x1234, LO = 0xFFFFFFFF, div_by_zero = 1. Next MUL start clears the flag.
- MTHI a = 0xCAFEF00D, then HIout = 1 → bus_out = 0xCAFEF00D next cycle, busy never set. LOout alone → bus_out = LO. Neither asserted → bus_out = 0.
- Interruptions (HI/LO preloaded):
  - abort at RUN iteration 10 → HI/LO keep preloaded values, no done pulse.
  - start during busy → ignored.
  - Clear pulse mid-RUN → all outputs 0.
- WIDTH = 8 regression: MUL 0x80 × 0x80 signed → HI = 0x40, LO = 0x00, done 9 edges after start.
